inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit feeding the control decoder and the datapath. It generates sequential program-counter requests to instruction memory, buffers returned instruction words in a 2-entry FIFO, and presents each word with its PC and pre-split `op`/`funct3`/`funct7` fields to the decode stage. It also accepts taken-jump/branch redirects from execute, flushing buffered and in-flight fetches.

## Interface
- `XLEN`, 32: PC and address width.
- `RESET_PC`, 0: first fetch address after reset; low 2 bits must be 0.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output XLEN: fetch address, word-aligned, stable while `imem_req` high and not granted.
- `imem_gnt` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: read data valid; at least 1 cycle after grant, in order.
- `imem_rdata` input 32: instruction word.
- `redirect_valid` input 1: execute has a taken jump/branch this cycle.
- `redirect_pc` input XLEN: target; bits [1:0] ignored, treated as 0.
- `inst_valid` output 1: `inst`/`inst_pc`/fields valid.
- `inst_ready` input 1: decode consumes the head entry when both valid and ready are high.
- `inst` output 32: instruction word.
- `inst_pc` output XLEN: PC of `inst`.
- `op` output 7: `inst[6:0]`. `funct3` output 3: `inst[14:12]`. `funct7` output 7: `inst[31:25]`.

## Operation
- Registers: `fetch_pc` (next address to request), 2-entry FIFO of {pc, word}, `count` (0–2), state.
- At most one outstanding memory transaction.
- States:
  - IDLE: none outstanding. Drive `imem_req`=1, `imem_addr`=`fetch_pc` iff `count` < 2, or `count` = 2 with a pop this cycle. On grant: `fetch_pc` += 4 and go to WAIT.
  - WAIT: one outstanding and wanted. `imem_req`=0. On `imem_rvalid`: push {pc, `imem_rdata`} and go to IDLE.
  - DRAIN: one outstanding and stale. `imem_req`=0. On `imem_rvalid`: discard the data and go to IDLE.
- Redirect (`redirect_valid`=1) has priority over everything else in its cycle:
  - FIFO cleared; `count`=0; any pop that cycle is void.
  - `fetch_pc` ← {`redirect_pc`[XLEN-1:2], 2'b00}.
  - From WAIT, or from IDLE with a grant in the same cycle: go to DRAIN.
  - From WAIT with `imem_rvalid` in the same cycle: the data is dropped and the state goes to IDLE.
  - In DRAIN: stay in DRAIN, or go to IDLE if `imem_rvalid` arrives that cycle.
- Push and pop in the same cycle: `count` unchanged, order preserved.
- Because at most one transaction is outstanding and requests need a free slot, the FIFO never overflows and a push into a full FIFO is impossible.
- PC arithmetic is modulo 2^XLEN: `fetch_pc` wraps from 2^XLEN−4 to 0.
- `op`/`funct3`/`funct7` are pure slices of the FIFO head.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `op`/`funct3`/`funct7`=0, state IDLE, `count`=0, `fetch_pc`=`RESET_PC`.
- First `imem_req`=1 is in the first cycle after `rst_n` deasserts.
- `imem_rvalid` in cycle N gives `inst_valid`=1 in cycle N+1.
- Redirect in cycle N gives `inst_valid`=0 in N+1. `imem_req` to the target is high in N+1 if no transaction is outstanding; otherwise in the cycle after the stale `imem_rvalid`.
- Throughput with 1-cycle memory (grant in N, rvalid in N+1): one instruction every 2 cycles.
- `rst_n` asserted mid-transaction: all state clears immediately. Memory must not return `imem_rvalid` for pre-reset requests, and the bench guarantees this.
- Outputs are registered, except `imem_req`/`imem_addr`, which come from state, `count` and `fetch_pc` plus a same-cycle pop term.

## Structure
- Shared `rv_pkg`: `XLEN`, instruction field bit positions (`OP_LSB`/`MSB`, `F3_LSB`/`MSB`, `F7_LSB`/`MSB`), and the state enum `{IDLE, WAIT, DRAIN}`.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO carrying {pc, word}, with push, pop, flush and count. Everything else lives in `inst_fetch`.

## Test plan
- Reset release, memory grants immediately, rvalid 1 cycle later, `inst_ready`=1 -> `inst_pc` sequence 0x0, 0x4, 0x8; `op`=`imem_rdata`[6:0]. For word 0x40005033: `funct7`=0x20, `funct3`=0x5, `op`=0x33.
- `inst_ready`=0 for 10 cycles -> exactly 2 entries buffered, `imem_req` stays low after the second grant, no data lost. Release -> in-order drain at 0x0, 0x4, then 0x8.
- Redirect to 0x102 while WAIT, rvalid 3 cycles later -> stale word never appears. Next `imem_addr`=0x100 after that rvalid. First `inst_pc`=0x100.
- Redirect in the same cycle as rvalid and a pop -> word dropped, `inst_valid`=0 next cycle, FIFO empty.
- `RESET_PC`=0xFFFFFFF8 -> `inst_pc` 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- `rst_n` pulsed low while 2 entries are held -> `inst_valid`=0 and `imem_req`=0 during reset; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 definitions: datapath width, instruction field positions and
// the fetch-unit transaction states.
package rv_pkg;

    localparam int XLEN = 32;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    // IDLE: nothing outstanding; WAIT: one wanted fetch outstanding;
    // DRAIN: one outstanding fetch whose data is stale after a redirect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, instruction word}. Entry 0 is always the head, so the
// head outputs come straight from registers.
module fetch_fifo #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_word,
    input  logic            pop,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_word,
    output logic [1:0]      count
);

    logic [XLEN-1:0] pc0, pc1;
    logic [31:0]     word0, word1;

    // Flush wins over push/pop; pushes land behind the live entries, pops
    // shift entry 1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc0   <= '0;
            pc1   <= '0;
            word0 <= '0;
            word1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            pc0   <= '0;
            word0 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0   <= push_pc;
                        word0 <= push_word;
                    end else begin
                        pc1   <= push_pc;
                        word1 <= push_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    pc0   <= pc1;
                    word0 <= word1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc0   <= push_pc;
                        word0 <= push_word;
                    end else begin
                        pc0   <= pc1;
                        word0 <= word1;
                        pc1   <= push_pc;
                        word1 <= push_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_pc   = pc0;
    assign head_word = word0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential PC requests with one transaction in
// flight, a two-entry instruction buffer and redirect/flush handling.
module inst_fetch #(
    parameter int              XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    import rv_pkg::*;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic            running;
    logic            pop_hs;
    logic            gnt_ok;
    logic            push;
    logic [1:0]      count;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_word;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop_hs = inst_valid & inst_ready;
    assign gnt_ok = imem_req & imem_gnt;

    // Holds requests off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) running <= 1'b0;
        else        running <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid)
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (gnt_ok)
                fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_ok) state_next = redirect_valid ? DRAIN : WAIT;
            WAIT: begin
                if (imem_rvalid)         state_next = IDLE;
                else if (redirect_valid) state_next = DRAIN;
            end
            DRAIN:   if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A slot freed by this cycle's pop may be refilled by this cycle's request.
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE:    imem_req = running & ((count != 2'd2) | pop_hs);
            WAIT:    push     = imem_rvalid & ~redirect_valid;
            default: ;
        endcase
    end

    assign imem_addr = fetch_pc;

    // In WAIT fetch_pc has already advanced past the outstanding request.
    fetch_fifo #(
        .XLEN(XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (fetch_pc - XLEN'(4)),
        .push_word (imem_rdata),
        .pop       (pop_hs & ~redirect_valid),
        .head_pc   (head_pc),
        .head_word (head_word),
        .count     (count)
    );

    assign inst_valid = (count != 2'd0);
    assign inst       = head_word;
    assign inst_pc    = head_pc;
    assign op         = head_word[OP_MSB:OP_LSB];
    assign funct3     = head_word[F3_MSB:F3_LSB];
    assign funct7     = head_word[F7_MSB:F7_LSB];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: scoreboard of expected {pc, word}
// pushed on grant, popped on every decode handshake.
module tb_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic        req_b;
    logic [31:0] addr_b;
    logic        gnt_b = 1'b0;
    logic        rvalid_b = 1'b0;
    logic [31:0] rdata_b = '0;
    logic        redir_b = 1'b0;
    logic [31:0] redir_pc_b = '0;
    logic        valid_b;
    logic        ready_b = 1'b1;
    logic [31:0] inst_b;
    logic [31:0] pc_b;
    logic [6:0]  op_b;
    logic [2:0]  f3_b;
    logic [6:0]  f7_b;

    inst_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .op(op), .funct3(funct3), .funct7(funct7)
    );

    inst_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt_b),
        .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
        .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
        .inst_valid(valid_b), .inst_ready(ready_b), .inst(inst_b),
        .inst_pc(pc_b), .op(op_b), .funct3(f3_b), .funct7(f7_b)
    );

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    vec_t        tbl [4];
    sb_t         sb [$];
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          grants = 0;
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_fetch = '0;

    // Words at 0x0..0xC come from the decode table; elsewhere a pattern of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return tbl[a[3:2]].word;
        return {a[26:2], 7'h33};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic popCheck();
        sb_t        e;
        logic [6:0] eop;
        logic [2:0] ef3;
        logic [6:0] ef7;
        pops++;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_inst actual pc=%h required=none", inst_pc);
        end else begin
            e = sb.pop_front();
            if (e.pc < 32'h10) begin
                eop = tbl[e.pc[3:2]].op;
                ef3 = tbl[e.pc[3:2]].f3;
                ef7 = tbl[e.pc[3:2]].f7;
            end else begin
                eop = e.word[6:0];
                ef3 = e.word[14:12];
                ef7 = e.word[31:25];
            end
            checkOutput("inst_pc", inst_pc, e.pc);
            checkOutput("inst", inst, e.word);
            checkOutput("op", 32'(op), 32'(eop));
            checkOutput("funct3", 32'(funct3), 32'(ef3));
            checkOutput("funct7", 32'(funct7), 32'(ef7));
        end
    endtask

    // One cycle: drive at the negedge, respond as memory, wait to the next negedge.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc, input logic gnt_en);
        if (inst_valid && rdy && !redir) popCheck();
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = 1'b0;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        #1;
        imem_gnt = gnt_en && imem_req;
        if (imem_gnt) begin
            grants++;
            checkOutput("imem_addr", imem_addr, exp_fetch);
            mem_addr = imem_addr;
            mem_busy = 1'b1;
            mem_wait = mem_lat - 1;
        end
        if (redir) begin
            sb.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end else if (imem_gnt) begin
            sb.push_back('{pc: exp_fetch, word: mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        gnt_b          = 1'b0;
        rvalid_b       = 1'b0;
        #1;
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_req_b", 32'(req_b), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        checkOutput("rst_fields", {18'b0, op, funct3, funct7}, 32'h0);
        checkOutput("rst_addr_b", addr_b, 32'hFFFF_FFF8);
        checkOutput("rst_b_outputs", {valid_b, 14'b0, op_b, f3_b, f7_b} | inst_b | pc_b, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        sb.delete();
        mem_busy  = 1'b0;
        mem_lat   = 1;
        exp_fetch = 32'h0;
    endtask

    initial begin
        logic [31:0] exp_b [3];
        bit          pend_b;
        int          got_b;

        tbl[0] = '{word: 32'h00c5_8593, op: 7'h13, f3: 3'h0, f7: 7'h00};
        tbl[1] = '{word: 32'h4000_5033, op: 7'h33, f3: 3'h5, f7: 7'h20};
        tbl[2] = '{word: 32'hfe1f_f06f, op: 7'h6f, f3: 3'h7, f7: 7'h7f};
        tbl[3] = '{word: 32'h00a1_2223, op: 7'h23, f3: 3'h2, f7: 7'h00};
        exp_b[0] = 32'hFFFF_FFF8;
        exp_b[1] = 32'hFFFF_FFFC;
        exp_b[2] = 32'h0000_0000;

        #2;
        $display("[TB] streaming fetch, 1-cycle memory");
        doReset();
        checkOutput("first_req", 32'(imem_req), 32'd1);
        pops = 0;
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stream_pops", 32'(pops), 32'd11);

        $display("[TB] backpressure then drain");
        doReset();
        grants = 0;
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_grants", 32'(grants), 32'd2);
        checkOutput("bp_req_low", 32'(imem_req), 32'd0);
        checkOutput("bp_valid", 32'(inst_valid), 32'd1);
        checkOutput("bp_head_pc", inst_pc, 32'h0);
        pops = 0;
        repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drain_pops", 32'(pops), 32'd6);

        $display("[TB] redirect while a fetch is outstanding");
        doReset();
        mem_lat = 4;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h102, 1'b1);
        checkOutput("rd_valid_low", 32'(inst_valid), 32'd0);
        checkOutput("rd_drain_req", 32'(imem_req), 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_req_after", 32'(imem_req), 32'd1);
        checkOutput("rd_addr_after", imem_addr, 32'h100);
        mem_lat = 1;
        pops = 0;
        repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rd_pops", 32'(pops), 32'd3);

        $display("[TB] redirect with rvalid and pop in the same cycle");
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("rv_pre_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
        checkOutput("rv_valid_low", 32'(inst_valid), 32'd0);
        checkOutput("rv_req", 32'(imem_req), 32'd1);
        checkOutput("rv_addr", imem_addr, 32'h200);
        pops = 0;
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rv_pops", 32'(pops), 32'd2);

        $display("[TB] reset while two entries are buffered");
        doReset();
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_full_valid", 32'(inst_valid), 32'd1);
        checkOutput("mr_full_req", 32'(imem_req), 32'd0);
        doReset();
        pops = 0;
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("mr_pops", 32'(pops), 32'd2);

        $display("[TB] RESET_PC near the top of the address space");
        doReset();
        pend_b = 1'b0;
        got_b  = 0;
        for (int c = 0; c < 40 && got_b < 3; c++) begin
            if (valid_b) begin
                checkOutput("wrap_inst_pc", pc_b, exp_b[got_b]);
                got_b++;
            end
            rvalid_b = pend_b;
            rdata_b  = 32'h0000_0013;
            pend_b   = 1'b0;
            #1;
            gnt_b = req_b;
            if (gnt_b) pend_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("wrap_count", 32'(got_b), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
